// File: rtl/rx_data_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_data_buffer_pkg
// Brief    : Shared USB receive-path constants and types.
// Revision : 1.0 - initial release
// ============================================================================
package rx_data_buffer_pkg;

   localparam int RX_BUFFER_DEPTH = 64;

   typedef logic [7:0] rx_byte_t;

endpackage : rx_data_buffer_pkg
`default_nettype wire

// File: rtl/rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_data_buffer
// Brief    : Circular byte buffer between usb_rx and the bus-side reader.
// Revision : 1.0 - initial release
// ============================================================================
module rx_data_buffer
   import rx_data_buffer_pkg::*;
#(
   parameter int DEPTH = RX_BUFFER_DEPTH  // power of two, at least 2
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     store_rx_packet_data,
   input  rx_byte_t                 rx_packet_data,
   input  logic                     get_rx_data,
   input  logic                     flush,
   output rx_byte_t                 rx_data,
   output logic [$clog2(DEPTH):0]   buffer_occupancy,
   output logic                     overflow_err,
   output logic                     underflow_err
);

   localparam int                AW         = $clog2(DEPTH);
   localparam logic [AW:0]       C_FULL     = (AW + 1)'(DEPTH);
   localparam logic [AW:0]       C_OCC_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0]     C_PTR_ONE  = AW'(1);

   rx_byte_t          r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_occ;
   rx_byte_t          r_rx_data;
   logic              r_ovf;
   logic              r_unf;

   logic              w_empty;
   logic              w_full;
   logic              w_rd_ok;
   logic              w_wr_ok;
   logic              w_wr_drop;
   logic              w_rd_empty;

   // A read only frees a slot when data is present, so an empty buffer never bypasses.
   assign w_empty    = (r_occ == '0);
   assign w_full     = (r_occ == C_FULL);
   assign w_rd_ok    = !flush && get_rx_data && !w_empty;
   assign w_wr_ok    = !flush && store_rx_packet_data && (!w_full || w_rd_ok);
   assign w_wr_drop  = !flush && store_rx_packet_data && !w_wr_ok;
   assign w_rd_empty = !flush && get_rx_data && w_empty;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr] <= rx_packet_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_rx_data <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else if (flush) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + C_PTR_ONE;
         end
         if (w_rd_ok) begin
            r_rx_data <= r_mem[r_rptr];
            r_rptr    <= r_rptr + C_PTR_ONE;
         end
         if (w_wr_ok && !w_rd_ok) begin
            r_occ <= r_occ + C_OCC_ONE;
         end else if (w_rd_ok && !w_wr_ok) begin
            r_occ <= r_occ - C_OCC_ONE;
         end
         if (w_wr_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_rd_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   assign rx_data          = r_rx_data;
   assign buffer_occupancy = r_occ;
   assign overflow_err     = r_ovf;
   assign underflow_err    = r_unf;

endmodule : rx_data_buffer
`default_nettype wire

// File: tb/tb_rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_data_buffer
// Brief    : Self-checking bench for rx_data_buffer (vector table + queue model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_data_buffer;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        store = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        get = 1'b0;
   logic        fl = 1'b0;
   logic [7:0]  rx;
   logic [6:0]  occ;
   logic        ovf;
   logic        unf;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mq  [$];   // model contents
   logic [7:0] sbq [$];   // expected read data awaiting DUT output
   logic [7:0] m_rx  = 8'h00;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       rd;
      logic       f;
      logic [6:0] occ;
      logic [7:0] rx;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t tbl [8];

   rx_data_buffer #(.DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .store_rx_packet_data (store),
      .rx_packet_data       (din),
      .get_rx_data          (get),
      .flush                (fl),
      .rx_data              (rx),
      .buffer_occupancy     (occ),
      .overflow_err         (ovf),
      .underflow_err        (unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the queue model predicts the result independently.
   task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic f);
      bit rd_ok;
      bit wr_ok;
      store = wr; din = d; get = rd; fl = f;
      if (f) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         rd_ok = rd && (mq.size() != 0);
         wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
         if (rd_ok) sbq.push_back(mq.pop_front());
         if (rd && !rd_ok) m_unf = 1'b1;
         if (wr && !wr_ok) m_ovf = 1'b1;
         if (wr_ok) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      if (sbq.size() != 0) m_rx = sbq.pop_front();
      chk("occupancy", 32'(occ), 32'(mq.size()));
      chk("rx_data", 32'(rx), 32'(m_rx));
      chk("overflow_err", 32'(ovf), 32'(m_ovf));
      chk("underflow_err", 32'(unf), 32'(m_unf));
      @(negedge clk);
      store = 1'b0; get = 1'b0; fl = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'hAF, 1'b0, 1'b0, 7'd1, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'hDD, 1'b0, 1'b0, 7'd2, 8'h00, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 8'h78, 1'b0, 1'b0, 7'd3, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd2, 8'hAF, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd1, 8'hDD, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 8'h78, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 8'h78, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 8'h42, 1'b1, 1'b0, 7'd1, 8'h78, 1'b0, 1'b1};

      // Reset state
      #12;
      chk("rst_occupancy", 32'(occ), 32'd0);
      chk("rst_rx_data", 32'(rx), 32'h00);
      chk("rst_overflow", 32'(ovf), 32'd0);
      chk("rst_underflow", 32'(unf), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // In-order, empty read, and empty simultaneous access
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].f);
         chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(tbl[i].occ));
         chk($sformatf("vec%0d_rx", i), 32'(rx), 32'(tbl[i].rx));
         chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
         chk($sformatf("vec%0d_unf", i), 32'(unf), 32'(tbl[i].unf));
      end

      // Full, then overflow, then drain
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk("full_occupancy", 32'(occ), 32'd64);
      chk("full_overflow", 32'(ovf), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("full_drain_data", 32'(rx), 32'(i));
      end
      chk("drained_occupancy", 32'(occ), 32'd0);

      // Simultaneous read+write at full
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b1, 1'b0);
      chk("sim_occupancy", 32'(occ), 32'd64);
      chk("sim_overflow", 32'(ovf), 32'd0);
      chk("sim_first_out", 32'(rx), 32'h40);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("sim_last_out", 32'(rx), 32'h99);

      // Empty read holds data; wrap with occupancy 1..2
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty_rd_unf", 32'(unf), 32'd1);
      chk("empty_rd_hold", 32'(rx), 32'h99);
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 8'($urandom), 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Flush with 10 bytes held and a concurrent write; flags set beforehand
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH - 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_flush_occ", 32'(occ), 32'd10);
      chk("pre_flush_ovf", 32'(ovf), 32'd1);
      step(1'b1, 8'h11, 1'b0, 1'b1);
      chk("flush_occ", 32'(occ), 32'd0);
      chk("flush_ovf", 32'(ovf), 32'd0);
      chk("flush_unf", 32'(unf), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_flush_unf", 32'(unf), 32'd1);

      // Asynchronous reset mid-transfer
      step(1'b1, 8'h01, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst_occ", 32'(occ), 32'd0);
      chk("arst_rx", 32'(rx), 32'h00);
      chk("arst_unf", 32'(unf), 32'd0);
      mq.delete(); sbq.delete();
      m_rx = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("arst_first_data", 32'(rx), 32'hAA);
      chk("arst_final_occ", 32'(occ), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rx_data_buffer
`default_nettype wire
